// File: rtl/rom_fetch.sv
// Instruction fetch front end: streams words from a 1-cycle-latency ROM into a 2-entry
// output FIFO, with out_valid/out_ready backpressure and a one-cycle flush-and-jump redirect.
module rom_fetch #(
  parameter logic [12:0] RESET_PC = 13'h0000
) (
  input  logic        clka,
  input  logic        rsta,
  output logic [12:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [12:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [12:0] out_pc
);

  logic [12:0] fpc;
  logic        inflight;
  logic [12:0] ipc;
  logic [1:0]  count;
  logic [12:0] tail_pc;
  logic [31:0] tail_data;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occ;
  logic [1:0]  count_after_pop;

  assign rom_addr  = fpc;
  assign out_valid = (count != 2'd0);

  // The FIFO head lives in the out_* registers; tail_* holds the second entry.
  always_comb begin
    pop             = out_valid && out_ready;
    push            = inflight && !redirect;
    occ             = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue           = !redirect && (occ < 3'd2);
    count_after_pop = count - {1'b0, pop};
  end

  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      fpc       <= RESET_PC;
      inflight  <= 1'b0;
      ipc       <= 13'h0;
      count     <= 2'd0;
      tail_pc   <= 13'h0;
      tail_data <= 32'h0;
      out_pc    <= 13'h0;
      out_data  <= 32'h0;
    end else if (redirect) begin
      // Any pop this edge has already been taken by the consumer; everything else is dropped.
      fpc      <= redirect_pc;
      inflight <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        ipc <= fpc;
        fpc <= fpc + 13'd1;
      end
      count <= count_after_pop + {1'b0, push};
      if (pop) begin
        out_pc   <= tail_pc;
        out_data <= tail_data;
      end
      // Issue throttling guarantees at most one entry remains when a push lands.
      if (push) begin
        if (count_after_pop == 2'd0) begin
          out_pc   <= ipc;
          out_data <= rom_data;
        end else begin
          tail_pc   <= ipc;
          tail_data <= rom_data;
        end
      end
    end
  end

endmodule

// File: doc/rom_fetch.md
ROM_FETCH -- requirements
Module: rom_fetch

Interface
REQ-001 Parameter RESET_PC, default 13'h0000, is the word address fetched first after reset.
REQ-002 clka  input  1  the single clock; all state updates on its rising edge.
REQ-003 rsta  input  1  asynchronous active-low reset; low clears all state immediately.
REQ-004 rom_addr  output  13  word address to the program ROM; the ROM returns the data one clka edge later.
REQ-005 rom_data  input  32  ROM read data; valid in the cycle after the edge that sampled rom_addr.
REQ-006 redirect  input  1  one-cycle flush-and-jump request.
REQ-007 redirect_pc  input  13  new fetch word address, sampled when redirect is high.
REQ-008 out_valid  output  1  out_data/out_pc hold a fetched word.
REQ-009 out_ready  input  1  consumer accepts the word; transfer occurs when out_valid and out_ready are both high.
REQ-010 out_data  output  32  fetched instruction word.
REQ-011 out_pc  output  13  word address out_data was read from.

Function
REQ-012 Internal state: fetch PC fpc[12:0], in-flight flag inflight with tag ipc[12:0], and a 2-entry FIFO of {pc, data}.
REQ-013 rom_addr is driven directly from fpc (registered; no combinational path from any input).
REQ-014 pop = out_valid && out_ready; issue = !redirect && (count + inflight - pop) < 2.
REQ-015 On issue: inflight <= 1, ipc <= fpc, fpc <= fpc + 1 (13-bit wrap, 13'h1FFF -> 13'h0000); without issue, fpc holds and inflight <= 0.
REQ-016 When inflight is 1 and redirect is low, {ipc, rom_data} is written into the FIFO at that edge; when inflight is 0, rom_data is ignored.
REQ-017 The FIFO never overflows; a push and pop on the same edge leave count unchanged.
REQ-018 out_valid = (count != 0); out_data/out_pc show the FIFO head, registered.
REQ-019 With out_ready held high and no redirect, throughput is one word per cycle with consecutive out_pc values.
REQ-020 With out_ready low, the FIFO fills to 2, issuing stops, rom_addr holds, and no word is lost or duplicated.
REQ-021 On an edge with redirect high: the pop (if any) completes, then the FIFO is emptied, inflight <= 0 (next-cycle rom_data discarded), and fpc <= redirect_pc.
REQ-022 Redirect takes priority over issue and push on the same edge.
REQ-023 After a redirect edge E0, fetching resumes as follows:
- E1: issue at redirect_pc.
- E2: capture.
- out_valid is high after E2 with out_pc = redirect_pc.
REQ-024 Back-to-back redirects: only the last redirect_pc is honored, and no words from earlier targets appear.
REQ-025 Redirect while the FIFO is empty or full behaves identically to REQ-021.

Reset
REQ-026 While rsta is low:
- fpc = RESET_PC, rom_addr = RESET_PC.
- inflight = 0, count = 0, out_valid = 0.
- out_data = 32'h0, out_pc = 13'h0.
REQ-027 Reset asserted mid-operation discards all buffered and in-flight words and takes effect without waiting for clka.
REQ-028 After rsta rises, the first edge issues RESET_PC, and out_valid rises after the second edge with out_pc = RESET_PC.

Verification
REQ-029 Reset release, RESET_PC=0, ROM word[n]=n*4, out_ready=1 -> out_valid after 2nd edge; out_pc 0,1,2,3... with out_data 0,4,8,12 on consecutive cycles.
REQ-030 Stall: out_ready low 5 cycles after streaming -> count=2, rom_addr constant; on release, out_pc continues with no gap or duplicate.
REQ-031 Redirect to 13'h0100 while FIFO full and a read in flight -> out_valid drops the next cycle; the next word has out_pc=13'h0100 and out_data=ROM[0x100].
REQ-032 Redirect coincident with a pop -> the popped word counts as transferred exactly once; the next word is from redirect_pc.
REQ-033 Redirect to 13'h1FFE with out_ready=1 -> out_pc 1FFE, 1FFF, 0000, 0001.
REQ-034 Assert rsta low mid-stream with FIFO full -> out_valid=0 and rom_addr=RESET_PC immediately; after release, REQ-028 timing holds.
